lsq_mmio_collector: RTL
=======================

Name: lsq_mmio_collector

Overview:
- Downstream consumer of the LSQ MMIO lane outputs: three lanes per cycle, each a `mmio` flag plus an 8-bit ROB index.
- Collects flagged lanes into an in-order FIFO.
- Issues each MMIO access to the uncache unit only when its ROB index equals the ROB dequeue pointer, so the access is non-speculative.
- Waits for the uncache response, then reports writeback; handles redirect flushes.

Parameters:
- DEPTH, 8, number of FIFO entries (power of two, at least 4).
- IDX_W, 8, ROB index width.
- CNT_W, 4, occupancy counter width; equals clog2(DEPTH+1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- io_lsq_mmio_0/1/2  in  1 each  lane N carries an MMIO op.
- io_lsq_uop_0/1/2_robIdx_value  in  IDX_W each  ROB index of lane N.
- io_lsq_ready  out  1  at least 3 free entries.
- io_rob_deq_value  in  IDX_W  ROB head index.
- io_redirect_valid  in  1  flush request.
- io_redirect_robIdx_value  in  IDX_W  flush boundary; this index and everything younger is flushed.
- io_uncache_req_valid  out  1  request valid.
- io_uncache_req_ready  in  1  request accepted.
- io_uncache_req_robIdx_value  out  IDX_W  request ROB index.
- io_uncache_resp_valid  in  1  response for the in-flight request.
- io_wb_valid  out  1  writeback pulse.
- io_wb_robIdx_value  out  IDX_W  writeback ROB index.
- io_count  out  CNT_W  FIFO occupancy.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - head pointer, tail pointer and count = 0.
  - FSM = IDLE.
  - io_uncache_req_valid = 0, io_wb_valid = 0, io_wb_robIdx_value = 0.
  - io_lsq_ready = 1 after reset.
  - A reset asserted mid-operation drops every entry and any in-flight request; a later response is ignored.
- Age arithmetic: age(x) = (x - io_rob_deq_value) mod 2^IDX_W, unsigned IDX_W bits, so wrap-around is handled.
- io_lsq_ready is combinational: (DEPTH - count) >= 3. Upstream must not present flagged lanes while ready = 0; such lanes are dropped.
- Enqueue:
  - Condition: io_lsq_ready=1 and io_redirect_valid=0.
  - Flagged lanes are compacted in lane order 0,1,2 into tail, tail+1, tail+2.
  - tail and count advance by popcount of the flags (0..3).
  - Pointers wrap modulo DEPTH.
- Redirect (io_redirect_valid=1):
  - Same-cycle enqueue is suppressed.
  - Entries are in program order, so the new tail is the first entry, scanning head to tail, whose age >= age(io_redirect_robIdx_value).
  - count is recomputed from the new tail.
  - The entry in flight in WAIT_RESP is exempt from the flush.
- FSM:
  - IDLE -> REQ when count > 0 and entry[head] == io_rob_deq_value. req_valid becomes 1 the next cycle.
  - REQ: req_valid=1, robIdx = entry[head]; valid is held until ready.
    - req_ready=1 -> WAIT_RESP.
    - A redirect that flushes the head entry while in REQ -> IDLE with req_valid=0. This is the only allowed valid drop.
  - WAIT_RESP: req_valid=0.
    - On resp_valid: pop head (head+1, count-1), load io_wb_robIdx_value = popped index, io_wb_valid=1 for exactly one cycle (registered, one cycle after resp), -> IDLE.
    - A resp_valid seen outside WAIT_RESP is ignored.
- Simultaneous events:
  - Pop and enqueue in the same cycle both apply; count = count + enq - 1.
  - Pop and redirect in the same cycle: pop is applied first, then the redirect tail truncation.
- Minimum request latency: entry written in cycle T, head match in T+1, req_valid in T+2.
- At most one uncache request is outstanding.

Test Plan:
- Reset, then lane0 mmio=1 idx=0x05 with deq=0x05, req_ready tied 1, resp two cycles after accept -> req_valid with idx 0x05 at T+2; wb_valid one-cycle pulse with wb_robIdx=0x05; count returns to 0.
- All three lanes flagged, idx 0x10/0x11/0x12, deq advanced 0x10 -> 0x11 -> 0x12 after each wb -> requests issue in order 0x10, 0x11, 0x12; a request never issues before deq matches.
- Fill to 6 entries with DEPTH=8 -> io_lsq_ready=0; one pop -> ready=1 (7 entries held? no: 5 held, 3 free).
- Queue 0x20..0x24, head 0x20 in WAIT_RESP, redirect idx 0x22 -> count=2 (0x20, 0x21 kept); 0x20 still completes on resp.
- Wrap case: deq=0xFE, entries 0xFE, 0xFF, 0x00, 0x01, redirect idx 0x00 -> 0x00 and 0x01 flushed, count=2.
- req_ready held 0 for 5 cycles -> req_valid and robIdx stay stable; rst asserted during WAIT_RESP -> all outputs 0, count=0, a later resp_valid produces no wb_valid.

Source files
------------

// File: rtl/lsq_mmio_collector.sv
// lsq_mmio_collector: in-order MMIO FIFO that issues to uncache only at the ROB head, with redirect flush
module lsq_mmio_collector #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             io_lsq_mmio_0,
    input  logic             io_lsq_mmio_1,
    input  logic             io_lsq_mmio_2,
    input  logic [IDX_W-1:0] io_lsq_uop_0_robIdx_value,
    input  logic [IDX_W-1:0] io_lsq_uop_1_robIdx_value,
    input  logic [IDX_W-1:0] io_lsq_uop_2_robIdx_value,
    output logic             io_lsq_ready,
    input  logic [IDX_W-1:0] io_rob_deq_value,
    input  logic             io_redirect_valid,
    input  logic [IDX_W-1:0] io_redirect_robIdx_value,
    output logic             io_uncache_req_valid,
    input  logic             io_uncache_req_ready,
    output logic [IDX_W-1:0] io_uncache_req_robIdx_value,
    input  logic             io_uncache_resp_valid,
    output logic             io_wb_valid,
    output logic [IDX_W-1:0] io_wb_robIdx_value,
    output logic [CNT_W-1:0] io_count
);
    localparam int PTR_W = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_t;
    state_t           state_q, state_d;
    logic [IDX_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, p1, p2;
    logic [CNT_W-1:0] count_q, count_d, keep;
    logic             wb_valid_q, wb_valid_d;
    logic [IDX_W-1:0] wb_idx_q, wb_idx_d, redir_age;
    logic             pop, enq, flushed, head_flush;
    logic [1:0]       n_enq;

    assign io_lsq_ready                = count_q <= CNT_W'(DEPTH - 3);
    assign io_uncache_req_valid        = state_q == REQ;
    assign io_uncache_req_robIdx_value = mem_q[head_q];
    assign io_wb_valid                 = wb_valid_q;
    assign io_wb_robIdx_value          = wb_idx_q;
    assign io_count                    = count_q;

    always_comb begin
        pop       = state_q == WAIT_RESP && io_uncache_resp_valid;
        enq       = io_lsq_ready && !io_redirect_valid;
        redir_age = io_redirect_robIdx_value - io_rob_deq_value;
        keep      = count_q;
        flushed   = 1'b0;
        // the entry already sent to uncache (head in WAIT_RESP) survives the flush
        for (int i = 0; i < DEPTH; i++) begin
            if (!flushed && CNT_W'(i) < count_q && !(i == 0 && state_q == WAIT_RESP) &&
                IDX_W'(mem_q[head_q + PTR_W'(i)] - io_rob_deq_value) >= redir_age) begin
                flushed = 1'b1;
                keep    = CNT_W'(i);
            end
        end
        head_flush = io_redirect_valid && flushed && keep == '0;
        mem_d = mem_q;
        p1    = tail_q + PTR_W'(io_lsq_mmio_0);
        p2    = p1 + PTR_W'(io_lsq_mmio_1);
        n_enq = 2'(io_lsq_mmio_0) + 2'(io_lsq_mmio_1) + 2'(io_lsq_mmio_2);
        if (enq && io_lsq_mmio_0) mem_d[tail_q] = io_lsq_uop_0_robIdx_value;
        if (enq && io_lsq_mmio_1) mem_d[p1] = io_lsq_uop_1_robIdx_value;
        if (enq && io_lsq_mmio_2) mem_d[p2] = io_lsq_uop_2_robIdx_value;
        head_d  = head_q + PTR_W'(pop);
        tail_d  = io_redirect_valid ? head_q + keep[PTR_W-1:0] : tail_q + (enq ? PTR_W'(n_enq) : '0);
        count_d = io_redirect_valid ? keep - CNT_W'(pop)
                                    : count_q + (enq ? CNT_W'(n_enq) : '0) - CNT_W'(pop);
        wb_valid_d = pop;
        wb_idx_d   = pop ? mem_q[head_q] : wb_idx_q;
        state_d    = state_q;
        case (state_q)
            IDLE:      if (count_q != '0 && mem_q[head_q] == io_rob_deq_value && !head_flush) state_d = REQ;
            REQ:       state_d = head_flush ? IDLE : io_uncache_req_ready ? WAIT_RESP : REQ;
            WAIT_RESP: if (io_uncache_resp_valid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mem_q      <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            wb_valid_q <= wb_valid_d;
            wb_idx_q   <= wb_idx_d;
        end
    end
endmodule
